dac_spi_out: RTL and testbench

Serial transmitter for the MAX5134 quad DAC. It captures a 24-bit command word (8-bit command/channel byte followed by a 16-bit sample) on a one-cycle `send` strobe and shifts it out MSB-first as a single chip-select-framed SPI transaction. It sits between the oscillator's sample-rate timer, which strobes once per sample interval (about every 2016 cycles at 88.67 MHz), and the DAC pins.

---
 rtl/dac_spi_out.sv | 209 ++++++++++++++++++++
 tb/tb_dac_spi_out.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dac_spi_out.sv
// -----------------------------------------------------------------------------
// dac_spi_out
//
// Serial transmitter for the MAX5134 quad DAC. A one-cycle (level-tested)
// `send` strobe captures a command word (command/channel byte followed by a
// 16-bit DAC code) and shifts it out MSB-first as one chip-select-framed SPI
// transaction. SCLK idles low; DIN changes on SCLK rising edges so it is
// stable when the DAC samples on the falling edge.
//
// Frame sequence (H = CLK_HALF, cycle 0 = accepting edge):
//   IDLE -> SETUP (H cycles, CS low, SCLK low)
//        -> SHIFT_HI / SHIFT_LO alternating, H cycles each, WORD_BITS times
//        -> HOLD (the low phase after the last falling edge, H cycles)
//        -> GAP  (CS high, busy still high, H cycles) -> IDLE
//
// Parameters:
//   CLK_HALF   clock_in cycles per SCLK half-period (>= 1)
//   WORD_BITS  frame length in bits (>= 2)
//
// Ports:
//   clock_in       in   system clock, rising edge
//   rstn           in   synchronous active-low reset
//   data_in        in   command word, captured when a frame is accepted
//   send           in   start request, sampled every cycle
//   busy           out  high from frame acceptance until the next may start
//   spi_cs_out     out  active-low DAC chip select
//   spi_clock_out  out  SCLK, idles low
//   spi_data_out   out  DIN, MSB first
// -----------------------------------------------------------------------------
module dac_spi_out #(
    parameter int CLK_HALF  = 2,
    parameter int WORD_BITS = 24
) (
    input  logic                 clock_in,
    input  logic                 rstn,
    input  logic [WORD_BITS-1:0] data_in,
    input  logic                 send,
    output logic                 busy,
    output logic                 spi_cs_out,
    output logic                 spi_clock_out,
    output logic                 spi_data_out
);

    // Counter widths: the phase counter holds 0..CLK_HALF-1, the bit counter
    // holds 0..WORD_BITS-1.
    localparam int CNT_W = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;
    localparam int BIT_W = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLK_HALF - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [BIT_W-1:0] BIT_ZERO   = BIT_W'(0);
    localparam logic [BIT_W-1:0] BIT_ONE    = BIT_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(WORD_BITS - 1);

    // FSM state encoding
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SETUP    = 3'd1;
    localparam logic [2:0] ST_SHIFT_HI = 3'd2;
    localparam logic [2:0] ST_SHIFT_LO = 3'd3;
    localparam logic [2:0] ST_HOLD     = 3'd4;
    localparam logic [2:0] ST_GAP      = 3'd5;

    logic [2:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q,   cnt_d;
    logic [BIT_W-1:0]     bit_q,   bit_d;
    logic [WORD_BITS-1:0] shreg_q, shreg_d;
    logic                 busy_q,  busy_d;
    logic                 cs_q,    cs_d;
    logic                 sclk_q,  sclk_d;
    logic                 din_q,   din_d;

    // The phase counter expires on the last cycle of the current half-period.
    logic phase_done_s;
    assign phase_done_s = (cnt_q == CNT_ZERO);

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        busy_d  = busy_q;
        cs_d    = cs_q;
        sclk_d  = sclk_q;
        din_d   = din_q;

        case (state_q)
            ST_IDLE: begin
                if (send) begin
                    // Capture the whole word now; later data_in changes are ignored.
                    shreg_d = data_in;
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = CNT_RELOAD;
                    bit_d   = BIT_ZERO;
                    state_d = ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_SETUP: begin
                if (phase_done_s) begin
                    // First rising edge presents the MSB.
                    sclk_d  = 1'b1;
                    din_d   = shreg_q[WORD_BITS-1];
                    cnt_d   = CNT_RELOAD;
                    state_d = ST_SHIFT_HI;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_SHIFT_HI: begin
                if (phase_done_s) begin
                    // Falling edge: DAC samples DIN here. DIN is left untouched
                    // and the register advances so the next bit is ready for
                    // the following rising edge.
                    sclk_d  = 1'b0;
                    shreg_d = {shreg_q[WORD_BITS-2:0], 1'b0};
                    cnt_d   = CNT_RELOAD;
                    if (bit_q == BIT_LAST) begin
                        state_d = ST_HOLD;
                    end else begin
                        bit_d   = bit_q + BIT_ONE;
                        state_d = ST_SHIFT_LO;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_SHIFT_LO: begin
                if (phase_done_s) begin
                    sclk_d  = 1'b1;
                    din_d   = shreg_q[WORD_BITS-1];
                    cnt_d   = CNT_RELOAD;
                    state_d = ST_SHIFT_HI;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_HOLD: begin
                if (phase_done_s) begin
                    // Close the frame: CS high and DIN parked low together.
                    cs_d    = 1'b1;
                    din_d   = 1'b0;
                    cnt_d   = CNT_RELOAD;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_GAP: begin
                if (phase_done_s) begin
                    // CS has been high for a full half-period; allow a new frame.
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            default: begin
                // Unreachable encodings recover to a quiet idle bus.
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
                bit_d   = BIT_ZERO;
                busy_d  = 1'b0;
                cs_d    = 1'b1;
                sclk_d  = 1'b0;
                din_d   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset; reset
    // abandons any frame in progress.
    always_ff @(posedge clock_in) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            bit_q   <= BIT_ZERO;
            shreg_q <= '0;
            busy_q  <= 1'b0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            din_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            busy_q  <= busy_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
            din_q   <= din_d;
        end
    end

    assign busy          = busy_q;
    assign spi_cs_out    = cs_q;
    assign spi_clock_out = sclk_q;
    assign spi_data_out  = din_q;

endmodule

// File: tb/tb_dac_spi_out.sv
// -----------------------------------------------------------------------------
// tb_dac_spi_out
//
// Two instances: CLK_HALF = 2 (main) and CLK_HALF = 1. Every cycle of every
// frame is compared against a waveform computed from the frame timing rules
// (cycle 0 = accepting edge), and the bits sampled on SCLK falling edges are
// reassembled into a word and compared against the word that was sent.
// -----------------------------------------------------------------------------
module tb_dac_spi_out;

    logic        clk;
    logic        rstn;
    logic        send2, send1;
    logic [23:0] data2, data1;
    logic        busy2, cs2, sclk2, din2;
    logic        busy1, cs1, sclk1, din1;

    int checks = 0;
    int errors = 0;

    dac_spi_out #(.CLK_HALF(2), .WORD_BITS(24)) u_dut2 (
        .clock_in      (clk),
        .rstn          (rstn),
        .data_in       (data2),
        .send          (send2),
        .busy          (busy2),
        .spi_cs_out    (cs2),
        .spi_clock_out (sclk2),
        .spi_data_out  (din2)
    );

    dac_spi_out #(.CLK_HALF(1), .WORD_BITS(24)) u_dut1 (
        .clock_in      (clk),
        .rstn          (rstn),
        .data_in       (data1),
        .send          (send1),
        .busy          (busy1),
        .spi_cs_out    (cs1),
        .spi_clock_out (sclk1),
        .spi_data_out  (din1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int h, input logic s, input logic [23:0] d);
        if (h == 2) begin
            send2 = s;
            data2 = d;
        end else begin
            send1 = s;
            data1 = d;
        end
    endtask

    task automatic sample(input int h, output logic cs, output logic sclk,
                          output logic din, output logic busy);
        if (h == 2) begin
            cs = cs2; sclk = sclk2; din = din2; busy = busy2;
        end else begin
            cs = cs1; sclk = sclk1; din = din1; busy = busy1;
        end
    endtask

    task automatic chk_idle(input int h, input string tag);
        logic cs, sclk, din, busy;
        sample(h, cs, sclk, din, busy);
        chk($sformatf("%s_cs_h%0d", tag, h),   {31'd0, cs},   32'd1);
        chk($sformatf("%s_sclk_h%0d", tag, h), {31'd0, sclk}, 32'd0);
        chk($sformatf("%s_din_h%0d", tag, h),  {31'd0, din},  32'd0);
        chk($sformatf("%s_busy_h%0d", tag, h), {31'd0, busy}, 32'd0);
    endtask

    // One frame. Called at a negedge; the next posedge is the accepting edge.
    //   hold     : keep send high (back-to-back), return right after cycle 50H+1
    //   glitch   : extra send pulses with new data at cycles 10 and 60
    //   abort_at : if > 0, assert reset at that cycle and check the abort
    task automatic run_frame(input int h, input logic [23:0] word, input bit hold,
                             input bit glitch, input int abort_at);
        logic        cs, sclk, din, busy;
        logic        psclk, pdin;
        logic [23:0] dec;
        int          rises, falls, last, k;
        logic        e_cs, e_sclk, e_din, e_busy;

        drive(h, 1'b1, word);
        psclk = 1'b0;
        pdin  = 1'b0;
        dec   = 24'd0;
        rises = 0;
        falls = 0;
        last  = hold ? (50 * h + 1) : (50 * h + 3);
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            sample(h, cs, sclk, din, busy);
            e_cs   = !(c >= 1 && c <= 49 * h);
            e_busy = (c >= 1 && c <= 50 * h);
            e_sclk = (c >= 1 + h) && (c <= 48 * h) && (((c - 1 - h) % (2 * h)) < h);
            if (c >= 1 + h && c <= 49 * h) begin
                k = (c - 1 - h) / (2 * h);
                if (k > 23) k = 23;
                e_din = word[23 - k];
            end else begin
                e_din = 1'b0;
            end
            chk($sformatf("cs_h%0d_c%0d", h, c),   {31'd0, cs},   {31'd0, e_cs});
            chk($sformatf("busy_h%0d_c%0d", h, c), {31'd0, busy}, {31'd0, e_busy});
            chk($sformatf("sclk_h%0d_c%0d", h, c), {31'd0, sclk}, {31'd0, e_sclk});
            chk($sformatf("din_h%0d_c%0d", h, c),  {31'd0, din},  {31'd0, e_din});
            if (!psclk && sclk) rises++;
            if (psclk && !sclk) begin
                falls++;
                chk($sformatf("din_stable_h%0d_c%0d", h, c), {31'd0, din}, {31'd0, pdin});
                dec = {dec[22:0], pdin};
            end
            psclk = sclk;
            pdin  = din;
            if (c == 1 && !hold) drive(h, 1'b0, word);
            if (glitch && (c == 10 || c == 60)) drive(h, 1'b1, 24'h311234);
            if (glitch && (c == 11 || c == 61)) drive(h, 1'b0, 24'h311234);
            if (c == abort_at) begin
                rstn = 1'b0;
                @(negedge clk);
                chk_idle(h, "abort");
                rstn = 1'b1;
                drive(h, 1'b0, word);
                return;
            end
        end
        chk($sformatf("word_h%0d", h),  {8'd0, dec}, {8'd0, word});
        chk($sformatf("rises_h%0d", h), rises, 32'd24);
        chk($sformatf("falls_h%0d", h), falls, 32'd24);
    endtask

    initial begin
        logic [23:0] w;
        rstn  = 1'b0;
        send2 = 1'b0;
        send1 = 1'b0;
        data2 = 24'd0;
        data1 = 24'd0;

        // Reset held for 3 edges
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle(2, "reset");
        chk_idle(1, "reset");
        rstn = 1'b1;

        // Outputs stay idle with send low
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk_idle(2, "quiet");
        end

        // Single mid-scale frame, then pattern and extreme codes
        run_frame(2, 24'h318000, 1'b0, 1'b0, 0);
        run_frame(2, 24'h310000, 1'b0, 1'b0, 0);
        run_frame(2, 24'h31FFFF, 1'b0, 1'b0, 0);
        run_frame(2, 24'h31A55A, 1'b0, 1'b0, 0);

        // Randomized words
        for (int i = 0; i < 4; i++) begin
            w = 24'($urandom);
            run_frame(2, w, 1'b0, 1'b0, 0);
        end

        // Strobes during a frame are ignored; trailing idle cycles show no new frame
        run_frame(2, 24'h31C3A5, 1'b0, 1'b1, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_idle(2, "post_glitch");
        end

        // Back-to-back frames with send held high
        run_frame(2, 24'h315555, 1'b1, 1'b0, 0);
        run_frame(2, 24'h32AAAA, 1'b1, 1'b0, 0);
        w = 24'($urandom);
        run_frame(2, w, 1'b0, 1'b0, 0);

        // Reset at cycle 40 of a frame, then a complete frame
        run_frame(2, 24'h31F00F, 1'b0, 1'b0, 40);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_idle(2, "post_abort");
        end
        run_frame(2, 24'h340F0F, 1'b0, 1'b0, 0);

        // CLK_HALF = 1 instance
        run_frame(1, 24'h318000, 1'b0, 1'b0, 0);
        run_frame(1, 24'h31A55A, 1'b0, 1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            w = 24'($urandom);
            run_frame(1, w, 1'b0, 1'b0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
